// File: rtl/counter_pkg.sv
// Shared definitions for the multi-channel event counter: register map,
// CTRL bit positions and the Wishbone byte-lane helper.
package counter_pkg;

    localparam int ADDR_CH_LSB  = 4;
    localparam int ADDR_REG_LSB = 2;

    typedef enum logic [1:0] {
        REG_CTRL  = 2'd0,
        REG_LOAD  = 2'd1,
        REG_CMP   = 2'd2,
        REG_COUNT = 2'd3
    } reg_sel_e;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_DIR     = 1;
    localparam int CTRL_SAT     = 2;
    localparam int CTRL_IE      = 3;
    localparam int CTRL_LD      = 4;
    localparam int CTRL_MATCH   = 8;
    localparam int CTRL_PSC_LSB = 16;
    localparam int CTRL_PSC_MSB = 23;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: CTRL/LOAD/CMP registers, up/down wrap/saturate counter,
// sticky compare match. Optional prescaler enabled by COUNTER_PRESCALE_EN.
module counter_channel
    import counter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  reg_sel_e         reg_sel,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_sel,
    input  logic             evt,
    output logic [31:0]      rd_data,
    output logic [WIDTH-1:0] count,
    output logic             match,
    output logic             irq_en
);

    localparam logic [WIDTH-1:0] MAX_CNT = '1;

    logic             en_q, dir_q, sat_q, ie_q, match_q;
    logic [WIDTH-1:0] load_q, cmp_q, count_q;
    logic [31:0]      mask;
    logic             ctrl_wr, do_load, w1c, tick, step, match_set;
    logic [WIDTH-1:0] stepped;

    // Wrap or hold at the range limits depending on SAT.
    function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] cur,
                                                  input logic dir, input logic sat);
        if (!dir)
            return (cur == MAX_CNT) ? (sat ? cur : '0) : cur + WIDTH'(1);
        else
            return (cur == '0) ? (sat ? cur : MAX_CNT) : cur - WIDTH'(1);
    endfunction

    assign mask      = lane_mask(wr_sel);
    assign ctrl_wr   = wr_en & (reg_sel == REG_CTRL);
    assign do_load   = ctrl_wr & wr_sel[0] & wr_data[CTRL_LD];
    assign w1c       = ctrl_wr & wr_sel[1] & wr_data[CTRL_MATCH];
    assign tick      = en_q & evt;
    assign stepped   = sat_step(count_q, dir_q, sat_q);
    // A saturated hold leaves the count unchanged and must not re-arm MATCH.
    assign match_set = step & ~do_load & (stepped != count_q) & (stepped == cmp_q);

`ifdef COUNTER_PRESCALE_EN
    logic [7:0] psc_q, pcnt_q;

    assign step = tick & (pcnt_q == psc_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psc_q  <= '0;
            pcnt_q <= '0;
        end else begin
            if (ctrl_wr && wr_sel[2])
                psc_q <= wr_data[CTRL_PSC_MSB:CTRL_PSC_LSB];
            if (ctrl_wr)
                pcnt_q <= '0;
            else if (tick)
                pcnt_q <= step ? 8'd0 : pcnt_q + 8'd1;
        end
    end
`else
    assign step = tick;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q    <= 1'b0;
            dir_q   <= 1'b0;
            sat_q   <= 1'b0;
            ie_q    <= 1'b0;
            match_q <= 1'b0;
            load_q  <= '0;
            cmp_q   <= '0;
            count_q <= '0;
        end else begin
            if (ctrl_wr && wr_sel[0]) begin
                en_q  <= wr_data[CTRL_EN];
                dir_q <= wr_data[CTRL_DIR];
                sat_q <= wr_data[CTRL_SAT];
                ie_q  <= wr_data[CTRL_IE];
            end
            if (wr_en && reg_sel == REG_LOAD)
                load_q <= (load_q & ~mask[WIDTH-1:0]) | (wr_data[WIDTH-1:0] & mask[WIDTH-1:0]);
            if (wr_en && reg_sel == REG_CMP)
                cmp_q <= (cmp_q & ~mask[WIDTH-1:0]) | (wr_data[WIDTH-1:0] & mask[WIDTH-1:0]);
            if (do_load)
                count_q <= load_q;
            else if (step)
                count_q <= stepped;
            if (match_set)
                match_q <= 1'b1;
            else if (w1c)
                match_q <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CTRL: begin
                rd_data[CTRL_EN]    = en_q;
                rd_data[CTRL_DIR]   = dir_q;
                rd_data[CTRL_SAT]   = sat_q;
                rd_data[CTRL_IE]    = ie_q;
                rd_data[CTRL_MATCH] = match_q;
`ifdef COUNTER_PRESCALE_EN
                rd_data[CTRL_PSC_MSB:CTRL_PSC_LSB] = psc_q;
`endif
            end
            REG_LOAD:  rd_data = 32'(load_q);
            REG_CMP:   rd_data = 32'(cmp_q);
            REG_COUNT: rd_data = 32'(count_q);
            default:   rd_data = '0;
        endcase
    end

    logic unused_wr;
    assign unused_wr = ^{wr_data, mask};

    assign count  = count_q;
    assign match  = match_q;
    assign irq_en = ie_q;

endmodule

// File: rtl/multi_channel_event_counter.sv
// N-channel event counter behind a Wishbone slave: address decode, registered
// single-cycle ack, read mux and interrupt OR. Prescaler via COUNTER_PRESCALE_EN.
module multi_channel_event_counter
    import counter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    input  logic [CHANNELS-1:0]       evt_i,
    output logic [CHANNELS*WIDTH-1:0] count_o,
    output logic                      irq_o
);

    logic          req;
    logic [1:0]    ch_idx;
    reg_sel_e      reg_sel;
    logic [31:0]   ch_rd [CHANNELS];
    logic [31:0]   rd_mux;
    logic [CHANNELS-1:0] ch_match, ch_ie;
    logic          ack_p1, irq_p1;
    logic [31:0]   rd_data_p1;

    // New request only when no ack is pending, so each access takes two cycles.
    assign req     = wbs_cyc_i & wbs_stb_i & ~ack_p1;
    assign ch_idx  = wbs_adr_i[ADDR_CH_LSB +: 2];
    assign reg_sel = reg_sel_e'(wbs_adr_i[ADDR_REG_LSB +: 2]);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        counter_channel #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_en   (req & wbs_we_i & (ch_idx == 2'(i))),
            .reg_sel (reg_sel),
            .wr_data (wbs_dat_i),
            .wr_sel  (wbs_sel_i),
            .evt     (evt_i[i]),
            .rd_data (ch_rd[i]),
            .count   (count_o[i*WIDTH +: WIDTH]),
            .match   (ch_match[i]),
            .irq_en  (ch_ie[i])
        );
    end

    // Channel indices with no instance fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (ch_idx == 2'(i))
                rd_mux = ch_rd[i];
    end

    // Stage p1: registered ack, read data and interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_p1     <= 1'b0;
            rd_data_p1 <= '0;
            irq_p1     <= 1'b0;
        end else begin
            ack_p1     <= req;
            rd_data_p1 <= (req & ~wbs_we_i) ? rd_mux : '0;
            irq_p1     <= |(ch_match & ch_ie);
        end
    end

    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[31:6], wbs_adr_i[1:0]};

    assign wbs_ack_o = ack_p1;
    assign wbs_dat_o = rd_data_p1;
    assign irq_o     = irq_p1;

endmodule

// File: tb/tb_multi_channel_event_counter.sv
// Scoreboard bench for multi_channel_event_counter (CHANNELS=2, WIDTH=16) with a
// cycle-level reference model; honours COUNTER_PRESCALE_EN when defined.
module tb_multi_channel_event_counter;

    localparam int CH = 2;
    localparam int W  = 16;
    localparam int unsigned MAXV = 32'h0000_FFFF;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]        sel = 4'h0;
    logic [31:0]       adr = '0, dat = '0;
    logic              ack;
    logic [31:0]       rdat;
    logic [CH-1:0]     evt = '0;
    logic [CH*W-1:0]   count;
    logic              irq;

    always #5 clk = ~clk;

    multi_channel_event_counter #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .evt_i     (evt),
        .count_o   (count),
        .irq_o     (irq)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] exp;
        string       nm;
    } sb_t;
    sb_t sbq[$];
    sb_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int unsigned m_cnt[CH], m_load[CH], m_cmp[CH], m_psc[CH], m_pcnt[CH];
    bit m_en[CH], m_dir[CH], m_sat[CH], m_ie[CH], m_match[CH];
    bit m_irq;
    // Bus access the model applies at the next rising edge
    bit          b_wr = 1'b0;
    logic [31:0] b_adr = '0, b_dat = '0;
    logic [3:0]  b_sel = '0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad < 40)
                $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0; m_load[c] = 0; m_cmp[c] = 0; m_psc[c] = 0; m_pcnt[c] = 0;
            m_en[c] = 0; m_dir[c] = 0; m_sat[c] = 0; m_ie[c] = 0; m_match[c] = 0;
        end
        m_irq = 0;
    endfunction

    function automatic int unsigned lanes(logic [3:0] s);
        int unsigned m = 0;
        for (int b = 0; b < 4; b++)
            if (s[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    // One clock of the specified behaviour, using the inputs the bench drives.
    function automatic void model_step();
        bit irq_n = 0;
        for (int c = 0; c < CH; c++) irq_n = irq_n | (m_match[c] & m_ie[c]);
        for (int c = 0; c < CH; c++) begin
            int unsigned nc = m_cnt[c];
            int unsigned lm;
            bit step = 0;
            bit set = 0;
            if (m_en[c] && evt[c]) begin
`ifdef COUNTER_PRESCALE_EN
                m_pcnt[c]++;
                if (m_pcnt[c] == m_psc[c] + 1) begin
                    step = 1;
                    m_pcnt[c] = 0;
                end
`else
                step = 1;
`endif
            end
            if (step) begin
                if (!m_dir[c]) nc = (m_cnt[c] == MAXV) ? (m_sat[c] ? MAXV : 0) : m_cnt[c] + 1;
                else           nc = (m_cnt[c] == 0) ? (m_sat[c] ? 0 : MAXV) : m_cnt[c] - 1;
                set = (nc != m_cnt[c]) && (nc == m_cmp[c]);
            end
            if (b_wr && int'(b_adr[5:4]) == c) begin
                lm = lanes(b_sel) & MAXV;
                case (b_adr[3:2])
                    2'd0: begin
                        if (b_sel[0]) begin
                            m_en[c] = b_dat[0]; m_dir[c] = b_dat[1];
                            m_sat[c] = b_dat[2]; m_ie[c] = b_dat[3];
                            if (b_dat[4]) begin
                                nc = m_load[c];
                                set = 0;
                            end
                        end
                        if (b_sel[1] && b_dat[8]) m_match[c] = 0;
`ifdef COUNTER_PRESCALE_EN
                        if (b_sel[2]) m_psc[c] = int'(b_dat[23:16]);
                        m_pcnt[c] = 0;
`endif
                    end
                    2'd1: m_load[c] = (m_load[c] & ~lm) | (b_dat & lm);
                    2'd2: m_cmp[c]  = (m_cmp[c] & ~lm) | (b_dat & lm);
                    default: ;
                endcase
            end
            if (set) m_match[c] = 1;
            m_cnt[c] = nc;
        end
        m_irq = irq_n;
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        int c = int'(a[5:4]);
        logic [31:0] r = '0;
        if (c >= CH) return '0;
        case (a[3:2])
            2'd0: begin
                r[0] = m_en[c]; r[1] = m_dir[c]; r[2] = m_sat[c]; r[3] = m_ie[c];
                r[8] = m_match[c];
`ifdef COUNTER_PRESCALE_EN
                r[23:16] = 8'(m_psc[c]);
`endif
            end
            2'd1: r = m_load[c];
            2'd2: r = m_cmp[c];
            default: r = m_cnt[c];
        endcase
        return r;
    endfunction

    function automatic logic [CH*W-1:0] exp_count();
        logic [CH*W-1:0] r;
        for (int c = 0; c < CH; c++) r[c*W +: W] = W'(m_cnt[c]);
        return r;
    endfunction

    // Monitor: live outputs every cycle, read data whenever an ack appears.
    bit prev_ack = 1'b0;
    always @(negedge clk) begin
        check("count_o", 32'(count), 32'(exp_count()));
        check("irq_o", 32'(irq), 32'(m_irq));
        if (ack) begin
            check("ack_one_cycle", 32'(prev_ack), 32'd0);
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack with no request outstanding at %0t", $time);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.is_rd) check(mon_e.nm, rdat, mon_e.exp);
            end
        end
        prev_ack = ack;
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        b_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_req(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                          bit use_exp, logic [31:0] exp, string nm);
        sb_t e;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        b_wr = w; b_adr = a; b_dat = d; b_sel = s;
        e.is_rd = !w;
        e.exp   = use_exp ? exp : model_read(a);
        e.nm    = nm;
        sbq.push_back(e);
        tick();
    endtask

    task automatic wb_end();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] s = 4'hF);
        wb_req(1'b1, a, d, s, 1'b0, '0, "wr");
        wb_end();
    endtask

    task automatic rd_chk(logic [31:0] a, logic [31:0] exp, string nm);
        wb_req(1'b0, a, '0, 4'hF, 1'b1, exp, nm);
        wb_end();
    endtask

    task automatic evts(logic [CH-1:0] e, int n);
        evt = e;
        repeat (n) tick();
        evt = '0;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h2;
            3: return 32'hFFFE;
            4: return 32'hFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        int          op;
        model_reset();
        #1 reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset arriving while a write is pending: nothing written, no ack.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h8; dat = 32'h55; sel = 4'hF;
        #2 reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        #2 reset_n = 1'b1;
        @(negedge clk);
        rd_chk(32'h8, 32'h0, "rst_mid_cmp");

        // Up-count of five events
        wr(32'h0, 32'h1);
        evts(2'b01, 5);
        rd_chk(32'hC, 32'd5, "t1_count0");
        rd_chk(32'h1C, 32'd0, "t1_count1");
        rd_chk(32'h2C, 32'd0, "t1_count2_absent");
        rd_chk(32'h3C, 32'd0, "t1_count3_absent");

        // Wrap past max, then saturate at max
        wr(32'h4, 32'hFFFE);
        wr(32'h0, 32'h11);
        evts(2'b01, 1);
        rd_chk(32'hC, 32'hFFFF, "t2_wrap_a");
        evts(2'b01, 1);
        rd_chk(32'hC, 32'h0000, "t2_wrap_b");
        evts(2'b01, 1);
        rd_chk(32'hC, 32'h0001, "t2_wrap_c");
        wr(32'h0, 32'h15);
        evts(2'b01, 3);
        rd_chk(32'hC, 32'hFFFF, "t2_sat_hold");

        // Down-count to CMP raises MATCH, irq one cycle later, W1C clears
        wr(32'h4, 32'h2);
        wr(32'h8, 32'h0);
        wr(32'h0, 32'h11B);
        evt = 2'b01;
        tick();
        tick();
        evt = '0;
        check("t3_irq_not_yet", 32'(irq), 32'd0);
        tick();
        check("t3_irq_set", 32'(irq), 32'd1);
        rd_chk(32'h0, 32'h10B, "t3_ctrl_match");
        wr(32'h0, 32'h10B);
        check("t3_irq_cleared", 32'(irq), 32'd0);
        rd_chk(32'h0, 32'h00B, "t3_ctrl_w1c");

        // Load and event in the same cycle: load wins
        wr(32'h0, 32'h1);
        wr(32'h4, 32'h10);
        evt = 2'b01;
        wb_req(1'b1, 32'h0, 32'h11, 4'hF, 1'b0, '0, "t4_wr");
        evt = '0;
        wb_end();
        rd_chk(32'hC, 32'h10, "t4_load_wins");

        // Absent channel and byte lanes
        rd_chk(32'h38, 32'h0, "t5_absent_rd");
        wr(32'h38, 32'hFFFF);
        rd_chk(32'h38, 32'h0, "t5_absent_wr");
        wr(32'h18, 32'hFFFF);
        wr(32'h18, 32'h1234, 4'h1);
        rd_chk(32'h18, 32'hFF34, "t5_cmp_lane0");
        wr(32'h10, 32'h0000_0001, 4'h2);
        rd_chk(32'h10, 32'h0, "t5_ctrl_lane1_only");

        // Prescaler 3 with twelve events
        wr(32'h10, 32'h0003_0011);
        evts(2'b10, 12);
`ifdef COUNTER_PRESCALE_EN
        rd_chk(32'h1C, 32'd3, "t6_psc_count");
        rd_chk(32'h10, 32'h0003_0001, "t6_psc_ctrl");
`else
        rd_chk(32'h1C, 32'd12, "t6_psc_count");
        rd_chk(32'h10, 32'h0000_0001, "t6_psc_ctrl");
`endif

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            op = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
            evt = CH'($urandom);
            if (op < 4) begin
                repeat ($urandom_range(1, 6)) tick();
            end else if (op < 7) begin
                if (a[3:2] == 2'd0)
                    d = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'h0003_011F);
                else
                    d = pick_val();
                s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                wb_req(1'b1, a, d, s, 1'b0, '0, "rand_wr");
                wb_end();
            end else begin
                wb_req(1'b0, a, '0, 4'hF, 1'b0, '0, "rand_rd");
                wb_end();
            end
            evt = '0;
        end

        repeat (3) tick();
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
